// File: rtl/debouncer_bank.sv
// debouncer_bank: N_CH push-button conditioners (sync, debounce, press/release, long-press, auto-repeat).
// Latency: pin stable at new level from edge k -> pb_state and pb_down/pb_up update on edge k+1+2^CNT_W.
// Backpressure: none; every output is a free-running level or a 1-cycle pulse that must be sampled when high.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pb         raw asynchronous button pins (polarity set by ACTIVE_LOW)
//   pb_state   debounced level, 1 = pressed
//   pb_down    1-cycle pulse in the first cycle pb_state shows 1
//   pb_up      1-cycle pulse in the first cycle pb_state shows 0
//   pb_long    1-cycle pulse once the press has been held LONG_TICKS hold ticks
//   pb_repeat  1-cycle pulse every REPEAT_TICKS hold ticks after pb_long (0 = never)
module debouncer_bank #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 16,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int TICK_W       = 16,
    parameter int HOLD_W       = 8,
    parameter int LONG_TICKS   = 64,
    parameter int REPEAT_TICKS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pb,
    output logic [N_CH-1:0] pb_state,
    output logic [N_CH-1:0] pb_down,
    output logic [N_CH-1:0] pb_up,
    output logic [N_CH-1:0] pb_long,
    output logic [N_CH-1:0] pb_repeat
);

    typedef enum logic [1:0] {
        H_IDLE      = 2'd0,
        H_WAIT_LONG = 2'd1,
        H_REPEAT    = 2'd2
    } hold_st_t;

    localparam logic [HOLD_W-1:0] LONG_C    = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0] REPEAT_C  = HOLD_W'(REPEAT_TICKS);
    localparam bit                REPEAT_EN = (REPEAT_TICKS != 0);

    // ------------------------------------------------------------------
    // Polarity normalisation and two-flop synchroniser. After the XOR a
    // pressed button is always 1, so reset value 0 means "released".
    // ------------------------------------------------------------------
    logic [N_CH-1:0] pb_norm;
    logic [N_CH-1:0] sync0_q;
    logic [N_CH-1:0] sync1_q;

    assign pb_norm = pb ^ {N_CH{ACTIVE_LOW}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            sync0_q <= pb_norm;
            sync1_q <= sync0_q;
        end
    end

    // ------------------------------------------------------------------
    // Shared hold-timebase prescaler. It free-runs and is never realigned
    // to a press, so the first hold tick after a press lands anywhere in
    // the next 2^TICK_W cycles.
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] presc_q;
    logic              tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + TICK_W'(1);
        end
    end

    assign tick = &presc_q;

    // ------------------------------------------------------------------
    // Per-channel debounce and hold logic
    // ------------------------------------------------------------------
    for (genvar c = 0; c < N_CH; c++) begin : g_ch

        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;
        logic              state_q;
        logic              state_d;
        logic              flip;
        logic              rise;
        logic              fall;
        logic              down_q;
        logic              up_q;

        hold_st_t          hst_q;
        logic [HOLD_W-1:0] hcnt_q;
        logic [HOLD_W-1:0] hcnt_inc;
        logic              long_q;
        logic              rep_q;

        // Count consecutive cycles where the synchronised pin disagrees
        // with the accepted level; one agreeing cycle restarts the count.
        // The level flips on the cycle after the counter saturates, so a
        // change needs exactly 2^CNT_W disagreeing cycles.
        always_comb begin
            flip  = 1'b0;
            cnt_d = '0;
            if (state_q != sync1_q[c]) begin
                if (&cnt_q) begin
                    flip = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        assign state_d = state_q ^ flip;
        assign rise    = flip & ~state_q;
        assign fall    = flip &  state_q;

        // down/up are registered on the same edge as the level change,
        // so they are high exactly in the first cycle of the new level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                state_q <= 1'b0;
                down_q  <= 1'b0;
                up_q    <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                state_q <= state_d;
                down_q  <= rise;
                up_q    <= fall;
            end
        end

        assign hcnt_inc = hcnt_q + HOLD_W'(1);

        // Hold FSM. A release is checked before anything else so a tick
        // coinciding with the release edge never produces long/repeat.
        // In H_IDLE the tick is ignored, so a tick on the accept edge is
        // not counted towards LONG_TICKS.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hst_q  <= H_IDLE;
                hcnt_q <= '0;
                long_q <= 1'b0;
                rep_q  <= 1'b0;
            end else begin
                long_q <= 1'b0;
                rep_q  <= 1'b0;
                if (fall) begin
                    hst_q  <= H_IDLE;
                    hcnt_q <= '0;
                end else begin
                    case (hst_q)
                        H_IDLE: begin
                            if (rise) begin
                                hst_q  <= H_WAIT_LONG;
                                hcnt_q <= '0;
                            end
                        end
                        H_WAIT_LONG: begin
                            if (tick) begin
                                if (hcnt_inc == LONG_C) begin
                                    long_q <= 1'b1;
                                    hcnt_q <= '0;
                                    hst_q  <= H_REPEAT;
                                end else begin
                                    hcnt_q <= hcnt_inc;
                                end
                            end
                        end
                        H_REPEAT: begin
                            if (tick && REPEAT_EN) begin
                                if (hcnt_inc == REPEAT_C) begin
                                    rep_q  <= 1'b1;
                                    hcnt_q <= '0;
                                end else begin
                                    hcnt_q <= hcnt_inc;
                                end
                            end
                        end
                        default: begin
                            hst_q  <= H_IDLE;
                            hcnt_q <= '0;
                        end
                    endcase
                end
            end
        end

        assign pb_state[c]  = state_q;
        assign pb_down[c]   = down_q;
        assign pb_up[c]     = up_q;
        assign pb_long[c]   = long_q;
        assign pb_repeat[c] = rep_q;
    end

endmodule

// File: doc/debouncer_bank.md
Name: debouncer_bank

Overview:
- Parametrised multi-channel push-button conditioner; successor to the single-channel debouncer.
- Per channel: 2-FF synchroniser, saturating-counter debounce, state output, registered press/release pulses, plus long-press detection and auto-repeat.
- Sits between raw board pins and UI/control FSMs (menu navigation, font/cursor stepping).
- One shared prescaler provides the hold timebase for all channels.

Parameters:
N_CH, 4, number of independent button channels
CNT_W, 16, debounce counter width; a state change needs 2^CNT_W consecutive disagreeing cycles
ACTIVE_LOW, 1, 1 = pins are active-low (inverted before sync); 0 = active-high
TICK_W, 16, prescaler width; one hold tick every 2^TICK_W clk cycles
HOLD_W, 8, width of per-channel hold counter
LONG_TICKS, 64, ticks of continuous press before long pulse (1..2^HOLD_W-1)
REPEAT_TICKS, 16, ticks between auto-repeat pulses after long press; 0 = repeat disabled

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pb  in  N_CH  raw asynchronous button pins
pb_state  out  N_CH  debounced level, 1 = pressed
pb_down  out  N_CH  1-cycle pulse, press accepted
pb_up  out  N_CH  1-cycle pulse, release accepted
pb_long  out  N_CH  1-cycle pulse, press held LONG_TICKS ticks
pb_repeat  out  N_CH  1-cycle pulse, auto-repeat while held after long

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-low, ports named clk and rst_n.
- Reset (rst_n=0, async assert, sync deassert by board): all sync FFs, counters, prescaler, flags and all outputs = 0. Sync FFs reset to the "released" level post-polarity.
- Polarity: s = pb ^ {N_CH{ACTIVE_LOW}}; then sync0 <= s, sync1 <= sync0 per channel.
- Debounce, per channel: idle = (pb_state == sync1).
  - idle: cnt <= 0.
  - not idle, cnt != all-ones: cnt <= cnt+1.
  - not idle, cnt == all-ones: pb_state <= ~pb_state; cnt <= 0.
- Any single agreeing cycle clears cnt; glitches shorter than 2^CNT_W cycles never change pb_state.
- Latency: pin stable at new level from edge k -> pb_state changes after edge k+1+2^CNT_W.
- pb_down / pb_up are registered and high exactly in the first cycle pb_state shows 1 / 0. They are never both high. At most one per channel per toggle.
- Prescaler: free-running TICK_W counter; tick = 1 for one cycle when it equals all-ones. Shared by all channels and not reset by presses, so the first long-press timing has up to 1 tick of jitter (accepted).
- Hold FSM per channel, states IDLE, WAIT_LONG, REPEAT:
  - IDLE -> WAIT_LONG on the press-accept edge; hcnt <= 0.
  - WAIT_LONG, on tick: hcnt+1; when hcnt+1 == LONG_TICKS -> pb_long pulse, hcnt <= 0, -> REPEAT.
  - REPEAT, on tick, REPEAT_TICKS != 0: hcnt+1; when == REPEAT_TICKS -> pb_repeat pulse, hcnt <= 0, stay.
  - REPEAT_TICKS == 0: REPEAT never pulses.
  - Any state with pb_state falling -> IDLE, hcnt <= 0.
- Priority: release beats tick in the same cycle. No pb_long/pb_repeat in the cycle pb_up is high or later.
- Press accepted on the same edge as a tick: that tick is not counted.
- Channels are fully independent. Simultaneous events on multiple channels produce simultaneous pulses.
- Reset mid-debounce or mid-hold: all state discarded. After reset, a still-held button needs a full debounce period before pb_down.

Test Plan:
- Params CNT_W=3, TICK_W=2, LONG_TICKS=3, REPEAT_TICKS=2, N_CH=2, ACTIVE_LOW=1. Drive pb[0] 1->0 at edge 10 -> pb_state[0]=1 and pb_down[0]=1 in the cycle after edge 19 only; pb_down low elsewhere; ch1 untouched.
- pb[0] low pulses of 5 cycles, separated by 1 high cycle, repeated 10x -> pb_state stays 0, no pulses (counter cleared by each agreeing cycle).
- Hold pb[0] low for 60 cycles after accept -> pb_long[0] once, 3 ticks (12±4 cycles) after accept; then pb_repeat[0] every 8 cycles until release.
- Release pb[0] in the cycle a tick would fire a repeat -> pb_up once, no pb_repeat, FSM back to IDLE; next press waits a full LONG_TICKS.
- Both channels pressed on the same edge -> pb_down=2'b11 in one cycle; pb_long pulses coincide.
- rst_n=0 mid-count while pb[1] held low -> all outputs 0 immediately (async). After release of reset, pb_down[1] follows exactly 2+2^CNT_W cycles later.
